booth_r4_seq_ctrl: RTL
======================

Name: booth_r4_seq_ctrl

Overview:
- Sequencing controller for the serial radix-4 Booth multiplier datapath.
- Accepts a start request carrying the signed multiplier y. Issues the multiplicand-register load and the accumulator clear.
- Then steps through WIDTH/2 Booth digits, one per cycle. Each cycle it drives partial-product select, negate and accumulate-enable to the datapath, then pulses done.
- Sits between the requester and the multiplicand register, partial-product mux and accumulator.

Parameters:
- WIDTH, 8, operand width in bits; must be even and at least 4.
- ITER, WIDTH/2, number of Booth digits (derived; do not override).
- CW, $clog2(ITER), width of digit_idx.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only when ready=1
- abort  in  1  synchronous cancel of an operation in progress
- y  in  WIDTH  signed multiplier, sampled on start acceptance
- ready  out  1  controller idle, can accept start
- busy  out  1  operation in progress (LOAD or RUN)
- done  out  1  one-cycle pulse: accumulator holds the final product
- load_x  out  1  datapath captures multiplicand x, ~x and x<<1 at the end of this cycle
- acc_clr  out  1  clear the accumulator
- acc_en  out  1  add the selected partial product into the accumulator
- pp_sel  out  2  00 zero, 01 X, 10 2X, 11 reserved (never driven)
- pp_neg  out  1  datapath uses the inverted operand and carry-in 1 (two's-complement negate)
- digit_idx  out  CW  index of the current Booth digit; the accumulator shift is 2*digit_idx

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset:
  - State=IDLE, window=0, count=0.
  - ready=1. busy, done, load_x, acc_clr, acc_en, pp_sel, pp_neg, digit_idx all 0.
- Moore outputs: every output is decoded from registered state, window and count only. No input-to-output combinational path.
- IDLE:
  - ready=1, all other outputs 0.
  - start=1 -> window <= {y,1'b0} (WIDTH+1 bits), count <= 0, next state LOAD.
  - abort in IDLE is ignored.
- LOAD (1 cycle):
  - busy=1, load_x=1, acc_clr=1.
  - The requester holds x stable from the start cycle through the end of LOAD.
  - Next state RUN.
- RUN (ITER cycles):
  - busy=1, acc_en=1, digit_idx=count.
  - Digit is decoded from window[2:0] (b2 b1 b0).
  - Digit table:
    - 000 and 111 -> sel 00, neg 0
    - 001 and 010 -> sel 01, neg 0
    - 011 -> sel 10, neg 0
    - 100 -> sel 10, neg 1
    - 101 and 110 -> sel 01, neg 1
  - Each cycle: window <= window arithmetically shifted right by 2 (sign-extend the MSB), count <= count+1.
  - When count==ITER-1: next state DONE, count wraps to 0.
- DONE (1 cycle):
  - done=1, busy=0, ready=0.
  - Next state IDLE.
  - The product is valid in the accumulator from the DONE cycle until the next acc_clr.
- Latency: start accepted at cycle T -> LOAD at T+1 -> RUN at T+2..T+ITER+1 -> done at T+ITER+2 -> ready at T+ITER+3.
- start while busy or in DONE: ignored, with no queuing; the requester must re-issue it after ready.
- abort=1 in LOAD or RUN:
  - Next state IDLE, with no done pulse. count and window are cleared.
  - The accumulator content is undefined.
- abort and start together in IDLE: start is accepted.
- Asynchronous reset mid-operation: immediate return to the reset values above, with no done pulse.
- Encoding pp_sel=11 is never produced.

Decomposition:
- Package booth_r4_pkg contains:
  - state enum {IDLE, LOAD, RUN, DONE}
  - pp_sel localparams PP_ZERO=2'b00, PP_X=2'b01, PP_2X=2'b10
  - a digit struct {sel, neg}
- Sub-module booth_r4_digit_enc: combinational, 3-bit triplet in, {pp_sel, pp_neg} out. It is instantiated once on window[2:0] and is reused by the parallel variant.
- The FSM, window shift register and counter live in the top module.

Test Plan:
- Reset then idle, WIDTH=8:
  - Stimulus: assert rst mid-RUN, release it, hold start=0 for 10 cycles.
  - Required: outputs at reset values, ready=1, no load_x/acc_en/done activity.
- y=8'h76, start pulse at T:
  - Required: load_x=acc_clr=1 at T+1.
  - RUN digits in order (sel,neg): (10,1), (10,0), (01,1), (10,0), i.e. -2,+2,-1,+2 = 118.
  - digit_idx 0..3; done=1 at T+6 only.
- y=8'h80: digits (00,0), (00,0), (00,0), (10,1) = -128. y=8'hFF: digits (01,1), (00,0), (00,0), (00,0) = -1.
- start held high continuously: a new LOAD follows every DONE by exactly one IDLE cycle; no start accepted while busy=1.
- abort at the second RUN cycle:
  - Required: next cycle state IDLE, ready=1, acc_en=0, no done pulse.
  - A following start with y=8'h01 yields digits (01,0), (00,0), (00,0), (00,0).
- Checks at every cycle: pp_sel never 11, and ready/busy/done are mutually exclusive.

Source files
------------

// File: rtl/booth_r4_pkg.sv
// Shared types and constants for the serial radix-4 Booth multiplier controller.
//   state_t : controller states
//   PP_*    : partial-product select encodings driven to the datapath mux
//   digit_t : decoded Booth digit {sel, neg}
package booth_r4_pkg;

  localparam int unsigned PP_SEL_W  = 2;
  localparam int unsigned TRIPLET_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [PP_SEL_W-1:0] PP_ZERO = 2'b00;
  localparam logic [PP_SEL_W-1:0] PP_X    = 2'b01;
  localparam logic [PP_SEL_W-1:0] PP_2X   = 2'b10;

  typedef struct packed {
    logic [PP_SEL_W-1:0] sel;
    logic                neg;
  } digit_t;

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth digit encoder: maps one overlapping multiplier triplet
// {b2,b1,b0} to a partial-product select and a negate flag.
//   triplet : input  3-bit window slice
//   digit_c : output {sel, neg}, purely combinational
module booth_r4_digit_enc
  import booth_r4_pkg::*;
(
  input  logic [TRIPLET_W-1:0] triplet,
  output digit_t               digit_c
);

  always_comb begin
    digit_c.sel = PP_ZERO;
    digit_c.neg = 1'b0;
    case (triplet)
      3'b001, 3'b010: begin digit_c.sel = PP_X;  digit_c.neg = 1'b0; end
      3'b011:         begin digit_c.sel = PP_2X; digit_c.neg = 1'b0; end
      3'b100:         begin digit_c.sel = PP_2X; digit_c.neg = 1'b1; end
      3'b101, 3'b110: begin digit_c.sel = PP_X;  digit_c.neg = 1'b1; end
      default:        begin digit_c.sel = PP_ZERO; digit_c.neg = 1'b0; end
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_ctrl.sv
// Sequencing controller for the serial radix-4 Booth multiplier datapath.
// Accepts a start with multiplier y, issues multiplicand load + accumulator
// clear, then steps one Booth digit per cycle and pulses done.
//   clk, rst            : clock, async active-high reset
//   start, abort, y     : request, cancel, signed multiplier
//   ready, busy, done   : status (exactly one is high every cycle)
//   load_x, acc_clr     : datapath load / accumulator clear (LOAD cycle)
//   acc_en, pp_sel,
//   pp_neg, digit_idx   : per-digit accumulate controls (RUN cycles)
module booth_r4_seq_ctrl
  import booth_r4_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned ITER  = WIDTH / 2,
  localparam int unsigned CW    = $clog2(ITER)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    y,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic                load_x,
  output logic                acc_clr,
  output logic                acc_en,
  output logic [PP_SEL_W-1:0] pp_sel,
  output logic                pp_neg,
  output logic [CW-1:0]       digit_idx
);

  localparam int unsigned WIN_W = WIDTH + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(ITER - 1);

  state_t              state_q, state_d;
  logic [WIN_W-1:0]    window_q, window_d;
  logic [CW-1:0]       count_q, count_d;

  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                load_x_q, load_x_d;
  logic                acc_en_q, acc_en_d;
  logic [PP_SEL_W-1:0] pp_sel_q, pp_sel_d;
  logic                pp_neg_q, pp_neg_d;
  logic [CW-1:0]       digit_idx_q, digit_idx_d;

  digit_t              digit_nxt_c;

  // Encode the digit the next cycle will see so pp_sel/pp_neg can be registered.
  booth_r4_digit_enc u_digit_enc (
    .triplet (window_d[2:0]),
    .digit_c (digit_nxt_c)
  );

  // Next-state, window shift and digit counter.
  always_comb begin
    state_d  = state_q;
    window_d = window_q;
    count_d  = count_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          window_d = {y, 1'b0};
          count_d  = '0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          window_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          window_d = '0;
          count_d  = '0;
          state_d  = IDLE;
        end else begin
          window_d = {{2{window_q[WIDTH]}}, window_q[WIDTH:2]};
          if (count_q == LAST_IDX) begin
            count_d = '0;
            state_d = DONE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from next-state values; flopped so outputs are pure Moore.
  always_comb begin
    ready_d     = (state_d == IDLE);
    busy_d      = (state_d == LOAD) || (state_d == RUN);
    done_d      = (state_d == DONE);
    load_x_d    = (state_d == LOAD);
    acc_en_d    = (state_d == RUN);
    pp_sel_d    = PP_ZERO;
    pp_neg_d    = 1'b0;
    digit_idx_d = '0;
    if (state_d == RUN) begin
      pp_sel_d    = digit_nxt_c.sel;
      pp_neg_d    = digit_nxt_c.neg;
      digit_idx_d = count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      window_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      load_x_q    <= 1'b0;
      acc_en_q    <= 1'b0;
      pp_sel_q    <= PP_ZERO;
      pp_neg_q    <= 1'b0;
      digit_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      window_q    <= window_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      load_x_q    <= load_x_d;
      acc_en_q    <= acc_en_d;
      pp_sel_q    <= pp_sel_d;
      pp_neg_q    <= pp_neg_d;
      digit_idx_q <= digit_idx_d;
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign load_x    = load_x_q;
  // Accumulator clear coincides with the multiplicand load.
  assign acc_clr   = load_x_q;
  assign acc_en    = acc_en_q;
  assign pp_sel    = pp_sel_q;
  assign pp_neg    = pp_neg_q;
  assign digit_idx = digit_idx_q;

endmodule
